// File: rtl/alu_seq_if.sv
// Purpose: request/response bundle between the microsequencer (master) and alu_seq (slave).
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    // request side
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             dec_in;

    // response side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;

    modport master (
        output in_valid, op, a, b, carry_in, dec_in, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_v, flag_n
    );

    modport slave (
        input  in_valid, op, a, b, carry_in, dec_in, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/alu_seq.sv
// Purpose: registered, handshaked WIDTH-bit ALU with held C/Z/V/N flags; ALU_DECIMAL_EN adds packed-BCD ADD/SUB.
// Latency: 1 cycle for binary ops, 2 cycles for decimal ADD/SUB (extra DEC_ADJ cycle); 1 op/cycle binary throughput.
// Backpressure: result and flags hold while out_valid && !out_ready; in_ready drops then and during DEC_ADJ.
module alu_seq #(
    parameter int WIDTH = 8   // must match the interface WIDTH; multiple of 4 when ALU_DECIMAL_EN is defined
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORA  = 4'd3;
    localparam logic [3:0] OP_EOR  = 4'd4;
    localparam logic [3:0] OP_ASL  = 4'd5;
    localparam logic [3:0] OP_LSR  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_DEC  = 4'd11;

    // ST_DEC_ADJ is only ever entered when decimal support is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEC_ADJ = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
        logic n;
    } flags_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic             in_ready;
    logic             out_valid;
    logic             accept;

    // Binary datapath, evaluated straight off the request bus in the accept cycle.
    logic [WIDTH:0]   bin_sum;
    logic [WIDTH-1:0] bin_b;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c;
    logic             bin_v;

`ifdef ALU_DECIMAL_EN
    // Operands held across the DEC_ADJ cycle; v_bin keeps the binary overflow
    // because V in decimal mode still reflects the binary sum.
    typedef struct packed {
        logic             sub;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             v_bin;
    } dec_req_t;

    dec_req_t         dec_q, dec_d;
    logic [WIDTH-1:0] bcd_res;
    logic             bcd_c;
    logic [4:0]       nib_sum;
    logic [3:0]       nib_b;
    logic             nib_cy;
`else
    logic             unused_dec;
    assign unused_dec = bus.dec_in;
`endif

    // out_valid is simply "a result is parked in DONE".
    assign out_valid = (state_q == ST_DONE);

    // DONE also accepts so a consumed result can be replaced in the same cycle.
    assign in_ready  = (state_q != ST_DEC_ADJ) && (!out_valid || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_v    = flags_q.v;
    assign bus.flag_n    = flags_q.n;

    // Binary ALU: result plus the C/V each op produces; ops that leave C or V alone pass the held flag through.
    always_comb begin
        bin_b   = bus.b;
        bin_sum = '0;
        bin_res = bus.a;
        bin_c   = flags_q.c;
        bin_v   = flags_q.v;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                if (bus.op == OP_SUB) begin
                    bin_b = ~bus.b;
                end
                bin_sum = {1'b0, bus.a} + {1'b0, bin_b} + (WIDTH+1)'(bus.carry_in);
                bin_res = bin_sum[MSB:0];
                bin_c   = bin_sum[WIDTH];
                bin_v   = (bus.a[MSB] == bin_b[MSB]) && (bin_sum[MSB] != bus.a[MSB]);
            end
            OP_CMP: begin
                bin_b   = ~bus.b;
                bin_sum = {1'b0, bus.a} + {1'b0, bin_b} + (WIDTH+1)'(1);
                bin_res = bin_sum[MSB:0];
                bin_c   = bin_sum[WIDTH];
            end
            OP_AND: bin_res = bus.a & bus.b;
            OP_ORA: bin_res = bus.a | bus.b;
            OP_EOR: bin_res = bus.a ^ bus.b;
            OP_ASL: begin
                bin_c   = bus.a[MSB];
                bin_res = {bus.a[MSB-1:0], 1'b0};
            end
            OP_LSR: begin
                bin_c   = bus.a[0];
                bin_res = {1'b0, bus.a[MSB:1]};
            end
            OP_ROL: begin
                bin_c   = bus.a[MSB];
                bin_res = {bus.a[MSB-1:0], bus.carry_in};
            end
            OP_ROR: begin
                bin_c   = bus.a[0];
                bin_res = {bus.carry_in, bus.a[MSB:1]};
            end
            OP_INC: bin_res = bus.a + WIDTH'(1);
            OP_DEC: bin_res = bus.a - WIDTH'(1);
            default: bin_res = bus.a;   // PASS and the unused opcodes
        endcase
    end

`ifdef ALU_DECIMAL_EN
    // Nibble-serial BCD adjust: ADD corrects digits above 9, SUB corrects on nibble borrow.
    always_comb begin
        bcd_res = '0;
        nib_cy  = dec_q.cin;
        nib_sum = '0;
        nib_b   = '0;
        for (int i = 0; i < WIDTH / 4; i++) begin
            nib_b   = dec_q.sub ? ~dec_q.b[4*i +: 4] : dec_q.b[4*i +: 4];
            nib_sum = {1'b0, dec_q.a[4*i +: 4]} + {1'b0, nib_b} + {4'b0, nib_cy};
            if (dec_q.sub) begin
                nib_cy              = nib_sum[4];
                bcd_res[4*i +: 4]   = nib_cy ? nib_sum[3:0] : nib_sum[3:0] - 4'd6;
            end else if (nib_sum > 5'd9) begin
                nib_cy              = 1'b1;
                bcd_res[4*i +: 4]   = nib_sum[3:0] + 4'd6;
            end else begin
                nib_cy              = 1'b0;
                bcd_res[4*i +: 4]   = nib_sum[3:0];
            end
        end
        bcd_c = nib_cy;
    end
`endif

    // Next-state, result and flag update; everything defaults to holding its current value.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_DECIMAL_EN
        dec_d    = dec_q;
`endif
        case (state_q)
`ifdef ALU_DECIMAL_EN
            ST_DEC_ADJ: begin
                result_d  = bcd_res;
                flags_d.c = bcd_c;
                flags_d.z = (bcd_res == '0);
                flags_d.v = dec_q.v_bin;
                flags_d.n = bcd_res[MSB];
                state_d   = ST_DONE;
            end
`endif
            default: begin
                if (out_valid && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
`ifdef ALU_DECIMAL_EN
                    if (bus.dec_in && ((bus.op == OP_ADD) || (bus.op == OP_SUB))) begin
                        dec_d.sub   = (bus.op == OP_SUB);
                        dec_d.a     = bus.a;
                        dec_d.b     = bus.b;
                        dec_d.cin   = bus.carry_in;
                        dec_d.v_bin = bin_v;
                        state_d     = ST_DEC_ADJ;
                    end else
`endif
                    begin
                        result_d  = bin_res;
                        flags_d.c = bin_c;
                        flags_d.z = (bin_res == '0);
                        flags_d.v = bin_v;
                        flags_d.n = bin_res[MSB];
                        state_d   = ST_DONE;
                    end
                end
            end
        endcase
    end

    // State, result and flag registers; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

`ifdef ALU_DECIMAL_EN
    // Captured decimal operands for the adjust cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Purpose: scoreboard bench for alu_seq; directed vectors, backpressure, reset mid-op and random traffic.
// Latency: expects 1 cycle binary, 2 cycles decimal (when ALU_DECIMAL_EN is defined).
// Backpressure: out_ready is held high, held low or randomised by a dedicated process.
module tb_alu_seq;
    localparam int W = 8;
`ifdef ALU_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         v;
        logic         n;
    } exp_t;

    logic clk;
    logic reset;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   total;
    int   bad;
    exp_t exp_q[$];
    logic m_c;
    logic m_v;
    int   ready_mode;   // 0 = hold low, 1 = hold high, 2 = random

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, got no summary, required summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int from_bcd(input int v);
        return (v >> 4) * 10 + (v & 15);
    endfunction

    // Reference model: integer arithmetic on operand values, flags tracked as plain state.
    function automatic exp_t model(input int op, input int a, input int b, input int cin, input int dec);
        int   r;
        int   s;
        int   sa;
        int   sb;
        logic c;
        logic v;
        exp_t e;
        c  = m_c;
        v  = m_v;
        r  = a;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin
                s = a + b + cin;
                c = (s > 255);
                r = s % 256;
                v = ((sa + sb + cin) > 127) || ((sa + sb + cin) < -128);
                if (DEC_EN && dec == 1) begin
                    s = from_bcd(a) + from_bcd(b) + cin;
                    c = (s >= 100);
                    r = to_bcd(s % 100);
                end
            end
            1: begin
                s = a - b - (1 - cin);
                c = (s >= 0);
                r = (s + 256) % 256;
                v = ((sa - sb - (1 - cin)) > 127) || ((sa - sb - (1 - cin)) < -128);
                if (DEC_EN && dec == 1) begin
                    s = from_bcd(a) - from_bcd(b) - (1 - cin);
                    c = (s >= 0);
                    r = to_bcd((s < 0) ? s + 100 : s);
                end
            end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  begin c = (a >= 128); r = (a * 2) % 256; end
            6:  begin c = ((a % 2) == 1); r = a / 2; end
            7:  begin c = (a >= 128); r = (a * 2 + cin) % 256; end
            8:  begin c = ((a % 2) == 1); r = a / 2 + cin * 128; end
            9:  begin c = (a >= b); r = (a - b + 256) % 256; end
            10: r = (a + 1) % 256;
            11: r = (a + 255) % 256;
            default: r = a;
        endcase
        m_c = c;
        m_v = v;
        e.r = r[W-1:0];
        e.c = c;
        e.z = (r == 0);
        e.v = v;
        e.n = (r >= 128);
        return e;
    endfunction

    // Presents a request and waits for the handshake; returns just before the accepting edge, in_valid still high.
    task automatic issue(input int op, input int a, input int b, input int cin, input int dec, output int waits);
        exp_t e;
        waits = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op       = op[3:0];
        bus.a        = a[W-1:0];
        bus.b        = b[W-1:0];
        bus.carry_in = cin[0];
        bus.dec_in   = dec[0];
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", waits);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        e = model(op, a, b, cin, dec);
        exp_q.push_back(e);
    endtask

    // Single request, in_valid dropped right after the accepting edge.
    task automatic issue_one(input int op, input int a, input int b, input int cin, input int dec);
        int w;
        issue(op, a, b, cin, dec, w);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // out_ready generator
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: every presented result must match the oldest expectation; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: result 0x%0h presented, required no output", bus.result);
                end else begin
                    chk("scoreboard", {bus.result, bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n}, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int w;
        int wsum;
        int op;
        int a;
        int b;
        int cin;
        int dec;
        total        = 0;
        bad          = 0;
        m_c          = 1'b0;
        m_v          = 1'b0;
        ready_mode   = 1;
        bus.in_valid = 1'b0;
        bus.op       = 4'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
        bus.dec_in   = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n}, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // directed vectors, each followed by its one-cycle latency check
        issue_one(0, 'h7F, 'h01, 0, 0);
        @(negedge clk);
        chk("add_latency", bus.out_valid, 1);
        chk("add_7f_01", {bus.result, bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n}, {8'h80, 1'b0, 1'b0, 1'b1, 1'b1});

        issue_one(9, 'h40, 'h40, 0, 0);
        @(negedge clk);
        chk("cmp_keeps_v", {bus.result, bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n}, {8'h00, 1'b1, 1'b1, 1'b1, 1'b0});

        issue_one(1, 'h00, 'h01, 1, 0);
        @(negedge clk);
        chk("sub_00_01", {bus.result, bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n}, {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});

        issue_one(8, 'h01, 'h00, 1, 0);
        @(negedge clk);
        chk("ror_01_c1", {bus.result, bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n}, {8'h80, 1'b1, 1'b0, 1'b0, 1'b1});

`ifdef ALU_DECIMAL_EN
        issue_one(0, 'h58, 'h46, 1, 1);
        @(negedge clk);
        chk("dec_gap_valid", bus.out_valid, 0);
        chk("dec_gap_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("dec_latency", bus.out_valid, 1);
        chk("dec_58_46", {bus.result, bus.flag_c}, {8'h05, 1'b1});
`else
        issue_one(0, 'h58, 'h46, 1, 1);
        @(negedge clk);
        chk("bin_latency", bus.out_valid, 1);
        chk("dec_in_ignored", {bus.result, bus.flag_c}, {8'h9F, 1'b0});
`endif

        // back-to-back binary ops with out_ready high: no stalls expected
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            issue(2 + i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 0, w);
            wsum += w;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("burst_stalls", wsum, 0);

        // backpressure: result parked, second request must wait
        ready_mode = 0;
        repeat (2) @(posedge clk);
        issue_one(0, 'h12, 'h34, 0, 0);
        bus.in_valid = 1'b1;
        bus.op       = 4'd10;
        bus.a        = 8'h55;
        bus.b        = 8'h00;
        bus.carry_in = 1'b0;
        bus.dec_in   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        ready_mode = 1;
        issue(10, 'h55, 'h00, 0, 0, w);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset right after accepting (DEC_ADJ in a decimal build): op is discarded
        issue_one(0, 'h58, 'h46, 1, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_c = 1'b0;
        m_v = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_result", bus.result, 0);
        chk("rst_mid_flags", {bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_n}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_quiet", bus.out_valid, 0);
        end

        // random traffic under random backpressure
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            op  = $urandom_range(0, 15);
            dec = $urandom_range(0, 1);
            cin = $urandom_range(0, 1);
            if (DEC_EN && dec == 1 && op <= 1) begin
                a = to_bcd($urandom_range(0, 99));
                b = to_bcd($urandom_range(0, 99));
            end else begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end
            issue(op, a, b, cin, dec, w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        ready_mode = 1;
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
